// File: rtl/ex2_pkg.sv
// Shared types and constants for the ex2 word format: 5-bit word, 8-bit serial frame,
// receiver FSM states and the 10..20 range window.
package ex2_pkg;

  localparam int unsigned EX2_W          = 5;
  localparam int unsigned EX2_FRAME_BITS = 8;
  localparam int unsigned EX2_RANGE_LO   = 10;
  localparam int unsigned EX2_RANGE_HI   = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } ex2_rx_state_t;

endpackage

// File: rtl/ex2_unrotate.sv
// Combinational inverse of the ex2 rotation: V = {P[2:0], P[4:3]} back to P, plus word parity.
// Zero latency, no flow control.
module ex2_unrotate
  import ex2_pkg::*;
(
  input  logic [EX2_W-1:0] v_i,
  output logic [EX2_W-1:0] p_o,
  output logic             par_o
);

  assign p_o   = {v_i[1:0], v_i[4:2]};
  assign par_o = ^v_i;

endmodule

// File: rtl/ex2_rx.sv
// Framed serial receiver: start(1), 5 data bits MSB first, parity, stop(0); result 1 cycle after stop edge.
// Single-entry valid/ready output; a word completing while the entry is held unaccepted is dropped (sticky overrun).
module ex2_rx
  import ex2_pkg::*;
#(
  parameter int unsigned W        = EX2_W,
  parameter int unsigned RANGE_LO = EX2_RANGE_LO,
  parameter int unsigned RANGE_HI = EX2_RANGE_HI
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_valid,
  input  logic         rx_bit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] p_out,
  output logic         par_err,
  output logic         in_range,
  output logic         frame_err,
  output logic         overrun
);

  localparam int unsigned CNT_W = $clog2(EX2_FRAME_BITS);
  localparam logic [W-1:0] LO_C = W'(RANGE_LO);
  localparam logic [W-1:0] HI_C = W'(RANGE_HI);

  ex2_rx_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     sh_q, sh_d;
  logic             parb_q, parb_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     p_q, p_d;
  logic             par_err_q, par_err_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic             word_done;
  logic             frame_bad;
  logic             load;
  logic [W-1:0]     dec_p;
  logic             dec_par;

  ex2_unrotate u_unrotate (
    .v_i  (sh_q),
    .p_o  (dec_p),
    .par_o(dec_par)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    parb_d    = parb_q;
    word_done = 1'b0;
    frame_bad = 1'b0;
    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_bit) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          sh_d = {sh_q[W-2:0], rx_bit};
          if (cnt_q == CNT_W'(W - 1)) state_d = PAR;
          else                        cnt_d   = cnt_q + CNT_W'(1);
        end
        PAR: begin
          parb_d  = rx_bit;
          state_d = STOP;
        end
        STOP: begin
          // A bad stop bit returns to IDLE; it is never taken as the next start bit.
          state_d = IDLE;
          if (rx_bit) frame_bad = 1'b1;
          else        word_done = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    load        = word_done && (!out_valid_q || out_ready);
    out_valid_d = load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    p_d         = load ? dec_p : p_q;
    par_err_d   = load ? (dec_par != parb_q) : par_err_q;
    frame_err_d = frame_bad;
    overrun_d   = overrun_q || (word_done && out_valid_q && !out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      parb_q      <= 1'b0;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      parb_q      <= parb_d;
      out_valid_q <= out_valid_d;
      p_q         <= p_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign p_out     = p_q;
  assign par_err   = par_err_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign in_range  = (p_q >= LO_C) && (p_q <= HI_C);

endmodule
